// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the transmit scheduler slice.
//   state_t   : scheduler FSM states
//   HDR_BASE  : constant upper bits of the header byte (OR'd with grant id)
//   N_REQ_DEF : default requester count
//   TMO_DEF   : default UART busy-rise timeout in cycles
package tx_scheduler_pkg;

   localparam int         N_REQ_DEF = 4;
   localparam int         TMO_DEF   = 8;
   localparam logic [7:0] HDR_BASE  = 8'hA0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HDR_SEND = 3'd1,
      S_HDR_HI   = 3'd2,
      S_HDR_LO   = 3'd3,
      S_PLD_SEND = 3'd4,
      S_PLD_HI   = 3'd5,
      S_PLD_LO   = 3'd6,
      S_DONE     = 3'd7
   } state_t;

endpackage

// File: rtl/tx_scheduler_if.sv
// Requester + UART side bundle of the transmit scheduler.
//   req/data_in/uart_busy          : driven by requesters and the UART (master)
//   ack/uart_transmit/uart_data    : driven by the scheduler (slave)
//   grant_id/sched_busy/err        : scheduler status
interface tx_scheduler_if
   import tx_scheduler_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DATA_BW = 8
);

   logic [N_REQ-1:0]         req;
   logic [N_REQ*DATA_BW-1:0] data_in;
   logic [N_REQ-1:0]         ack;
   logic                     uart_busy;
   logic                     uart_transmit;
   logic [DATA_BW-1:0]       uart_data;
   logic [1:0]               grant_id;
   logic                     sched_busy;
   logic                     err;

   modport master (
      output req, data_in, uart_busy,
      input  ack, uart_transmit, uart_data, grant_id, sched_busy, err
   );

   modport slave (
      input  req, data_in, uart_busy,
      output ack, uart_transmit, uart_data, grant_id, sched_busy, err
   );

endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// Round-robin requester selection.
//   req         : pending requests
//   last_served : index served most recently; search starts one above it
//   valid       : at least one request pending
//   idx         : winning requester
module rr_arbiter
   import tx_scheduler_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       last_served,
   output logic             valid,
   output logic [1:0]       idx
);

   int unsigned      cand;
   logic [N_REQ-1:0] rot;

   // Walk offsets 1..N_REQ from last_served; the first hit wins, so the
   // last-served requester itself is checked last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      rot   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = (32'(last_served) + k) % N_REQ;
         rot  = req >> cand;
         if (!valid && rot[0]) begin
            valid = 1'b1;
            idx   = 2'(cand);
         end
      end
   end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin transmit scheduler: serves one requester at a time and sends a
// two-frame packet (header HDR_BASE|grant_id, then latched payload) through a
// UART using a transmit pulse / busy handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tx_scheduler_if.slave (requests, payloads, acks, UART, status)
module tx_scheduler
   import tx_scheduler_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DATA_BW = 8,
   parameter int TMO     = TMO_DEF
) (
   input  logic          clk,
   input  logic          rst,
   tx_scheduler_if.slave bus
);

   localparam int CW = $clog2(TMO + 1);

   state_t             state_q, state_d;
   logic [1:0]         grant_id_q, grant_id_d;
   logic [1:0]         last_q, last_d;
   logic [DATA_BW-1:0] payload_q, payload_d;
   logic [DATA_BW-1:0] uart_data_q, uart_data_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic               arb_valid;
   logic [1:0]         arb_idx;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req         (bus.req),
      .last_served (last_q),
      .valid       (arb_valid),
      .idx         (arb_idx)
   );

   assign cnt_inc = (cnt_q == CW'(TMO)) ? cnt_q : cnt_q + 1'b1;

   // Outputs are computed alongside the next state so they are registered
   // and line up with the state they belong to.
   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      last_d      = last_q;
      payload_d   = payload_q;
      uart_data_d = uart_data_q;
      ack_d       = '0;
      tx_d        = 1'b0;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            uart_data_d = '0;
            if (arb_valid && !bus.uart_busy) begin
               state_d     = S_HDR_SEND;
               grant_id_d  = arb_idx;
               payload_d   = DATA_BW'(bus.data_in >> (int'(arb_idx) * DATA_BW));
               uart_data_d = DATA_BW'(HDR_BASE) | DATA_BW'(arb_idx);
               tx_d        = 1'b1;
            end
         end
         S_HDR_SEND: begin
            state_d = S_HDR_HI;
            cnt_d   = '0;
         end
         S_HDR_HI, S_PLD_HI: begin
            if (bus.uart_busy) begin
               state_d = (state_q == S_HDR_HI) ? S_HDR_LO : S_PLD_LO;
            end else begin
               cnt_d = cnt_inc;
               // Abort: the requester is treated as served so arbitration moves on.
               if (cnt_inc == CW'(TMO)) begin
                  state_d     = S_IDLE;
                  err_d       = 1'b1;
                  last_d      = grant_id_q;
                  uart_data_d = '0;
               end
            end
         end
         S_HDR_LO: begin
            if (!bus.uart_busy) begin
               state_d     = S_PLD_SEND;
               tx_d        = 1'b1;
               uart_data_d = payload_q;
            end
         end
         S_PLD_SEND: begin
            state_d = S_PLD_HI;
            cnt_d   = '0;
         end
         S_PLD_LO: begin
            if (!bus.uart_busy) begin
               state_d     = S_DONE;
               ack_d       = N_REQ'(1) << grant_id_q;
               uart_data_d = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            last_d  = grant_id_q;
         end
         default: begin
            state_d     = S_IDLE;
            uart_data_d = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_id_q  <= '0;
         last_q      <= 2'(N_REQ - 1);
         payload_q   <= '0;
         uart_data_q <= '0;
         ack_q       <= '0;
         tx_q        <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         last_q      <= last_d;
         payload_q   <= payload_d;
         uart_data_q <= uart_data_d;
         ack_q       <= ack_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.ack           = ack_q;
   assign bus.uart_transmit = tx_q;
   assign bus.uart_data     = uart_data_q;
   assign bus.grant_id      = grant_id_q;
   assign bus.sched_busy    = busy_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: stimulus pushes expected UART bytes,
// acks and error events; a monitor pops and compares as the DUT emits them.
module tb_tx_scheduler;

   localparam int NR    = 4;
   localparam int BW    = 8;
   localparam int TMO_T = 8;
   localparam int K_TX  = 0;
   localparam int K_ACK = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic model_busy = 1'b0;
   logic force_busy = 1'b0;
   logic uart_en = 1'b1;
   logic err_prev = 1'b0;
   int   passed = 0;
   int   total = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   tx_scheduler_if #(.N_REQ(NR), .DATA_BW(BW)) bus ();

   tx_scheduler #(.N_REQ(NR), .DATA_BW(BW), .TMO(TMO_T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.uart_busy = model_busy | force_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input int kind, input logic [7:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      sbq.push_back(e);
   endtask

   task automatic sb_check(input int kind, input logic [7:0] val);
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         $display("FAIL sb_unexpected: got kind %0d val %0h expected nothing", kind, val);
      end else begin
         e = sbq.pop_front();
         chk("sb_kind", 32'(kind), 32'(e.kind));
         chk("sb_val", 32'(val), 32'(e.val));
      end
   endtask

   // UART model: busy rises one cycle after a transmit pulse, held 11 cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_en && !rst && bus.uart_transmit) begin
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (11) @(posedge clk);
            #1 model_busy = 1'b0;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.uart_transmit) sb_check(K_TX, bus.uart_data);
         if (|bus.ack) sb_check(K_ACK, 8'(bus.ack));
         if (bus.err && !err_prev) sb_check(K_ERR, 8'h00);
      end
      err_prev <= bus.err;
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      force_busy = 1'b0;
      uart_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_acks(input string name, input int n, input int budget);
      int got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         if (|bus.ack) got++;
      end
      chk(name, 32'(got), 32'(n));
   endtask

   task automatic wait_tx(input string name, input int n, input int budget);
      int got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         if (bus.uart_transmit) got++;
      end
      chk(name, 32'(got), 32'(n));
   endtask

   task automatic push_pkt(input int id, input logic [7:0] pld);
      push(K_TX, 8'hA0 | 8'(id));
      push(K_TX, pld);
      push(K_ACK, 8'(4'b0001 << id));
   endtask

   initial begin
      int cyc;
      bus.req = '0;
      bus.data_in = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 32'h0);
      chk("rst_tx", 32'(bus.uart_transmit), 32'h0);
      chk("rst_data", 32'(bus.uart_data), 32'h0);
      chk("rst_grant", 32'(bus.grant_id), 32'h0);
      chk("rst_busy", 32'(bus.sched_busy), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);

      // Single packet from requester 0
      do_reset();
      bus.data_in = {8'h00, 8'h00, 8'h00, 8'h5C};
      push_pkt(0, 8'h5C);
      bus.req = 4'b0001;
      wait_acks("pkt0_ack", 1, 200);
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("pkt0_drain", 32'(sbq.size()), 32'h0);

      // All requesters held: round-robin order 0,1,2,3,0
      do_reset();
      bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};
      push_pkt(0, 8'h11);
      push_pkt(1, 8'h22);
      push_pkt(2, 8'h33);
      push_pkt(3, 8'h44);
      push_pkt(0, 8'h11);
      bus.req = 4'b1111;
      wait_acks("rr_acks", 5, 400);
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("rr_drain", 32'(sbq.size()), 32'h0);

      // UART never responds: timeout after TMO cycles in HDR_HI
      do_reset();
      uart_en = 1'b0;
      bus.data_in = {8'h00, 8'h77, 8'h00, 8'h00};
      push(K_TX, 8'hA2);
      push(K_ERR, 8'h00);
      bus.req = 4'b0100;
      wait_tx("tmo_hdr", 1, 50);
      cyc = 0;
      while (!bus.err && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      bus.req = '0;
      chk("tmo_latency", 32'(cyc), 32'(TMO_T + 1));
      chk("tmo_idle", 32'(bus.sched_busy), 32'h0);
      chk("tmo_noack", 32'(bus.ack), 32'h0);
      repeat (4) @(negedge clk);
      chk("tmo_sticky", 32'(bus.err), 32'h1);
      chk("tmo_drain", 32'(sbq.size()), 32'h0);
      uart_en = 1'b1;

      // Payload latched at grant; later data_in change ignored
      do_reset();
      bus.data_in = {8'h00, 8'h11, 8'h00, 8'h00};
      push_pkt(2, 8'h11);
      bus.req = 4'b0100;
      wait_tx("latch_hdr", 1, 50);
      repeat (4) @(negedge clk);
      bus.data_in = {8'h00, 8'h22, 8'h00, 8'h00};
      wait_acks("latch_ack", 1, 200);
      bus.req = '0;
      chk("latch_err", 32'(bus.err), 32'h0);
      repeat (3) @(negedge clk);
      chk("latch_drain", 32'(sbq.size()), 32'h0);

      // Reset in PLD_HI aborts; next packet restarts with header
      do_reset();
      bus.data_in = {8'h00, 8'h00, 8'h3C, 8'h00};
      push(K_TX, 8'hA1);
      push(K_TX, 8'h3C);
      bus.req = 4'b0010;
      wait_tx("abort_tx", 2, 100);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_tx0", 32'(bus.uart_transmit), 32'h0);
      chk("abort_data", 32'(bus.uart_data), 32'h0);
      chk("abort_grant", 32'(bus.grant_id), 32'h0);
      chk("abort_busy", 32'(bus.sched_busy), 32'h0);
      chk("abort_ack", 32'(bus.ack), 32'h0);
      chk("abort_q", 32'(sbq.size()), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_pkt(1, 8'h3C);
      wait_acks("abort_restart", 1, 300);
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("abort_drain", 32'(sbq.size()), 32'h0);

      // UART busy in IDLE blocks the grant
      do_reset();
      force_busy = 1'b1;
      bus.data_in = {8'h00, 8'h00, 8'h5A, 8'h00};
      bus.req = 4'b0010;
      repeat (6) @(negedge clk);
      chk("blk_nogrant", 32'(bus.sched_busy), 32'h0);
      push_pkt(1, 8'h5A);
      force_busy = 1'b0;
      wait_acks("blk_ack", 1, 200);
      chk("blk_grant_id", 32'(bus.grant_id), 32'h1);
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("blk_drain", 32'(sbq.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
